// File: rtl/count_display_pkg.sv
// Shared types and constants for the count display driver: scan states,
// the blank pattern and the decimal-digit segment table (active-high).
package count_display_pkg;

   typedef enum logic [0:0] {
      S_ONES = 1'b0,
      S_TENS = 1'b1
   } scan_state_t;

   // Active-high pattern with no segment lit; polarity is applied at the output.
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Bit order {g,f,e,d,c,b,a}, lit segments as 1.
   localparam logic [6:0] SEG_LUT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational decimal digit to active-high 7-segment pattern.
// Codes above 9 decode to a blank digit.
module seg7_decoder
   import count_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = SEG_BLANK;
      if (digit <= 4'd9) pattern = SEG_LUT[digit];
   end

endmodule

// File: rtl/count_display_driver.sv
// Two-digit multiplexed 7-segment driver for a 0..15 count, with 15->5 wrap
// detection. Optional build macro: LEADING_ZERO_BLANK_EN (blank a zero tens digit).
module count_display_driver
   import count_display_pkg::*;
#(
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] count,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       wrap_pulse
);

   localparam int              PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0]   PS_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [6:0]      SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
   localparam logic [1:0]      AN_OFF  = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

   logic [3:0]    count_q;
   logic [PW-1:0] prescaler;
   logic          tick;
   scan_state_t   state;
   logic          tens_s;
   logic [3:0]    ones_s;
   logic [3:0]    digit;
   logic [6:0]    pattern;
   logic [6:0]    seg_lit;
   logic [1:0]    an_en;

   assign tick = (prescaler == PS_LAST);

   always_comb begin
      digit   = (state == S_TENS) ? {3'b000, tens_s} : ones_s;
      an_en   = (state == S_TENS) ? 2'b10 : 2'b01;
      seg_lit = pattern;
`ifdef LEADING_ZERO_BLANK_EN
      if ((state == S_TENS) && !tens_s) begin
         an_en   = 2'b00;
         seg_lit = SEG_BLANK;
      end
`else
`endif
   end

   seg7_decoder u_dec (
      .digit   (digit),
      .pattern (pattern)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= 4'd0;
         prescaler  <= '0;
         state      <= S_ONES;
         tens_s     <= 1'b0;
         ones_s     <= 4'd0;
         seg        <= SEG_OFF;
         an         <= AN_OFF;
         wrap_pulse <= 1'b0;
      end else begin
         count_q   <= count;
         prescaler <= tick ? '0 : prescaler + PW'(1);
         if (tick) begin
            state <= (state == S_ONES) ? S_TENS : S_ONES;
            // A new frame starts: freeze both digits so they cannot tear.
            if (state == S_TENS) begin
               tens_s <= (count_q >= 4'd10);
               ones_s <= (count_q >= 4'd10) ? count_q - 4'd10 : count_q;
            end
         end
         seg        <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
         an         <= AN_ACTIVE_LOW ? ~an_en : an_en;
         wrap_pulse <= (count_q == 4'd15) && (count == 4'd5);
      end
   end

endmodule
